fp_norm_round_pack: RTL and testbench
=====================================

# fp_norm_round_pack

Post-adder normalize/round/pack stage for the single-precision add/subtract datapath. It sits at the consuming end of the 26-bit mantissa adder and takes a raw magnitude sum, its exponent, its sign and its sticky bit. It normalizes iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE754 binary32 word. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- MANT_W, 26, raw mantissa width. Bit 25 is the carry position, bit 24 the hidden bit, bits 23:1 the fraction, bit 0 the guard bit.
- EXP_W, 8, exponent width. Bias is 127.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  high only in IDLE.
- in_mant  in  26  raw adder magnitude.
- in_exp  in  8  biased exponent of the larger operand. Legal range is 1..254; specials and denormal inputs are handled upstream, and a denormal input arrives with exponent 1.
- in_sign  in  1  result sign.
- in_sticky  in  1  OR of bits shifted out during alignment.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts.
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- out_inexact  out  1  guard or sticky was nonzero at rounding.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result is denormal or zero and inexact.

## Operation
- The FSM has four states: IDLE, NORM, ROUND, OUT.
- IDLE: on in_valid&&in_ready, register the mantissa m, exponent e, sign s and sticky t.
  - If in_mant==0 and in_sticky==0, load out_result=32'h00000000 (exact cancellation gives +0) with all flags 0, and go to OUT.
  - Otherwise go to NORM.
- NORM: evaluate one case per cycle.
  - If m[25]: m>>=1, t|=m[0] (old bit 0), e+=1.
    - If the new e==255, go to OUT with infinity {s, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Else if m[24]==0 and e>1: m<<=1 with 0 shifted into bit 0, e-=1.
  - Else go to ROUND.
  - A right shift happens at most once. Left shifts are at most 24.
- ROUND:
  - g=m[0], lsb=m[1], up = g & (t | lsb).
  - Compute r = m[24:1] + up (25-bit result).
  - If r[24] (carry out): fraction=0 and e+=1. If e becomes 255, the result is infinity with overflow=1.
  - Else if e==1 and r[23]==0: the result is denormal and the packed exponent is 0. A rounding carry into the hidden bit naturally gives packed exponent 1.
  - Otherwise exponent=e and fraction=r[22:0].
  - inexact = g|t. underflow = inexact & (packed exponent==0).
  - Go to OUT.
- OUT: out_valid=1. out_result and the flags are stable while waiting. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. No input is lost, because in_ready is low.

## Timing
- Reset values: state=IDLE, in_ready=1 (after reset deasserts), out_valid=0, out_result=0, all flags 0, internal registers 0.
- Reset asserted in any state aborts the operation immediately. No output is produced.
- Latency counts from the accept edge to the first cycle with out_valid high: 3 + k cycles, where k is the number of shifts (0..24).
  - Zero result: 1 cycle.
  - Overflow on right shift: 2 cycles.
- Throughput is one result per (latency + 1) cycles at best, because in_ready rises only after the OUT handshake.
- out_valid falls on the edge where out_valid&&out_ready. in_ready rises in the same cycle as that fall.
- Outputs are registered. There is no combinational path from in_* to out_*.

## Test plan
- Carry normalize: in_mant=26'h2000000, in_exp=127, sign 0, sticky 0 -> out_result=32'h40000000, flags 0, out_valid 4 cycles after accept.
- Massive cancellation: in_mant=26'h0000002, in_exp=127 -> 23 left shifts, out_result=32'h34000000, out_valid 26 cycles after accept.
- Round-to-even:
  - in_mant=26'h1000001, in_exp=127 -> 32'h3F800000, inexact=1.
  - in_mant=26'h1000003 -> 32'h3F800002, inexact=1.
  - in_mant=26'h1000001 with sticky=1 -> 32'h3F800001.
- Rounding overflow: in_mant=26'h1FFFFFF, in_exp=254 -> 32'h7F800000, overflow=1, inexact=1.
- Denormal:
  - in_mant=26'h0000400, in_exp=3, sign 1 -> 2 shifts, 32'h80000800, underflow=0.
  - Same with sticky=1 and guard set -> underflow=1.
- Zero, backpressure and reset:
  - in_mant=0, sticky 0 -> 32'h00000000 after 1 cycle.
  - Hold out_ready low 5 cycles -> out_valid and data stable, in_ready 0.
  - Assert rst during NORM of scenario 2 -> out_valid stays 0, in_ready 1 after release, the next operation is correct.

Source files
------------

// File: rtl/fp_norm_round_pack.sv
// Normalize/round/pack stage behind the single-precision mantissa adder.
// Normalizes one bit per cycle, rounds to nearest-even, emits a binary32 word.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | one normalizing shift (right or left) per cycle
// ROUND | round-to-nearest-even and pack
// OUT   | result held until out_ready
module fp_norm_round_pack #(
  parameter int MANT_W = 26,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_inexact,
  output logic              out_overflow,
  output logic              out_underflow
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t            state;
  logic [MANT_W-1:0] m;
  logic [EXP_W-1:0]  e;
  logic              s;
  logic              t;

  logic              g;
  logic              up;
  logic [MANT_W-2:0] r;
  logic [EXP_W-1:0]  pack_exp;
  logic [22:0]       pack_frac;
  logic              pack_ovf;
  logic              pack_ix;

  assign in_ready = (state == IDLE);

  always_comb begin
    g         = m[0];
    up        = g & (t | m[1]);
    r         = {1'b0, m[MANT_W-2:1]} + {{(MANT_W-2){1'b0}}, up};
    pack_exp  = e;
    pack_frac = r[22:0];
    pack_ovf  = 1'b0;
    pack_ix   = g | t;
    if (r[MANT_W-2]) begin
      pack_frac = '0;
      if (e == EXP_W'(254)) begin
        pack_exp = '1;
        pack_ovf = 1'b1;
      end else begin
        pack_exp = e + EXP_W'(1);
      end
    end else if (e == EXP_W'(1) && !r[MANT_W-3]) begin
      // denormal: hidden bit still clear after rounding
      pack_exp = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      m             <= '0;
      e             <= '0;
      s             <= 1'b0;
      t             <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m <= in_mant;
            e <= in_exp;
            s <= in_sign;
            t <= in_sticky;
            if (in_mant == '0 && !in_sticky) begin
              out_result    <= '0;
              out_inexact   <= 1'b0;
              out_overflow  <= 1'b0;
              out_underflow <= 1'b0;
              out_valid     <= 1'b1;
              state         <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (m[MANT_W-1]) begin
            m <= m >> 1;
            t <= t | m[0];
            e <= e + EXP_W'(1);
            if (e == EXP_W'(254)) begin
              out_result    <= {s, 8'hFF, 23'b0};
              out_inexact   <= 1'b1;
              out_overflow  <= 1'b1;
              out_underflow <= 1'b0;
              out_valid     <= 1'b1;
              state         <= OUT;
            end
          end else if (!m[MANT_W-2] && e > EXP_W'(1)) begin
            m <= m << 1;
            e <= e - EXP_W'(1);
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_result    <= {s, pack_exp, pack_frac};
          out_inexact   <= pack_ix;
          out_overflow  <= pack_ovf;
          out_underflow <= pack_ix & (pack_exp == '0);
          out_valid     <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Scenario bench for fp_norm_round_pack: hand-derived expected words and
// latencies queued at issue time, popped when the result appears.
module tb_fp_norm_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_mant;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_inexact;
  logic        out_overflow;
  logic        out_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ix;
    logic        ov;
    logic        uf;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_norm_round_pack #(.MANT_W(26), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_inexact(out_inexact),
    .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  // Issue one operand, wait for its result, optionally stall, then hand it off.
  task automatic run_op(input string name, input logic [25:0] mant, input logic [7:0] ex,
                        input logic sg, input logic st, input logic [31:0] eres,
                        input logic eix, input logic eov, input logic euf,
                        input int elat, input int hold);
    exp_t x;
    int   lat;
    logic busy_bad;
    logic [31:0] held;
    x.res = eres; x.ix = eix; x.ov = eov; x.uf = euf; x.lat = elat;
    sb.push_back(x);
    in_mant = mant; in_exp = ex; in_sign = sg; in_sticky = st; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready_at_issue got=%b want=1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 64) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL %s timeout out_valid=%b after %0d cycles", name, out_valid, lat);
    end
    total++;
    if (out_result !== x.res) begin
      bad++; $display("FAIL %s result got=%h want=%h", name, out_result, x.res);
    end
    total++;
    if ({out_inexact, out_overflow, out_underflow} !== {x.ix, x.ov, x.uf}) begin
      bad++; $display("FAIL %s flags(ix,ov,uf) got=%b%b%b want=%b%b%b", name,
                      out_inexact, out_overflow, out_underflow, x.ix, x.ov, x.uf);
    end
    total++;
    if (lat != x.lat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, x.lat);
    end
    total++;
    if (busy_bad || in_ready !== 1'b0) begin
      bad++; $display("FAIL %s in_ready_busy got=%b want=0", name, in_ready);
    end
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      // junk on the input side must be ignored while a result is held
      in_valid = 1'b1; in_mant = 26'h3FFFFFF; in_exp = 8'd200;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        bad++; $display("FAIL %s stall%0d valid=%b result=%h ready=%b want 1/%h/0",
                        name, i, out_valid, out_result, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s handoff valid=%b ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mant = '0; in_exp = '0; in_sign = 1'b0; in_sticky = 1'b0;
    #12;
    total++;
    if ({out_valid, out_result, out_inexact, out_overflow, out_underflow} !== 36'h0) begin
      bad++; $display("FAIL reset outputs got=%b/%h/%b%b%b want 0", out_valid, out_result,
                      out_inexact, out_overflow, out_underflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_normalize;
    run_op("carry",      26'h2000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("cancel",     26'h0000002, 8'd127, 1'b0, 1'b0, 32'h34000000, 1'b0, 1'b0, 1'b0, 26, 0);
    run_op("carry_stk",  26'h2000003, 8'd127, 1'b0, 1'b0, 32'h40000001, 1'b1, 1'b0, 1'b0, 4, 0);
    run_op("plain_neg",  26'h1800000, 8'd130, 1'b1, 1'b0, 32'hC1400000, 1'b0, 1'b0, 1'b0, 3, 0);
  endtask

  task automatic test_rounding;
    run_op("rne_tie_dn", 26'h1000001, 8'd127, 1'b0, 1'b0, 32'h3F800000, 1'b1, 1'b0, 1'b0, 3, 0);
    run_op("rne_tie_up", 26'h1000003, 8'd127, 1'b0, 1'b0, 32'h3F800002, 1'b1, 1'b0, 1'b0, 3, 0);
    run_op("rne_sticky", 26'h1000001, 8'd127, 1'b0, 1'b1, 32'h3F800001, 1'b1, 1'b0, 1'b0, 3, 0);
    run_op("rnd_carry",  26'h1FFFFFF, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0, 3, 0);
  endtask

  task automatic test_overflow;
    run_op("rnd_ovf",    26'h1FFFFFF, 8'd254, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b1, 1'b0, 3, 0);
    run_op("shift_ovf",  26'h2000000, 8'd254, 1'b1, 1'b0, 32'hFF800000, 1'b1, 1'b1, 1'b0, 2, 0);
  endtask

  task automatic test_denormal;
    run_op("denorm",     26'h0000400, 8'd3, 1'b1, 1'b0, 32'h80000800, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op("denorm_ix",  26'h0000400, 8'd3, 1'b1, 1'b1, 32'h80000800, 1'b1, 1'b0, 1'b1, 5, 0);
    run_op("denorm_up",  26'h0FFFFFF, 8'd1, 1'b0, 1'b0, 32'h00800000, 1'b1, 1'b0, 1'b0, 3, 0);
    run_op("sticky_only",26'h0000000, 8'd5, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 7, 0);
  endtask

  task automatic test_zero;
    run_op("zero",       26'h0000000, 8'd100, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_backpressure;
    run_op("stall",      26'h1000003, 8'd127, 1'b0, 1'b0, 32'h3F800002, 1'b1, 1'b0, 1'b0, 3, 5);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_a",      26'h2000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("b2b_b",      26'h0000000, 8'd9,   1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("b2b_c",      26'h1000001, 8'd127, 1'b0, 1'b1, 32'h3F800001, 1'b1, 1'b0, 1'b0, 3, 0);
  endtask

  task automatic test_reset_abort;
    logic seen;
    in_mant = 26'h0000002; in_exp = 8'd127; in_sign = 1'b0; in_sticky = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL abort valid_in_reset got=%b want=0", out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL abort quiet got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    run_op("after_abort", 26'h0000002, 8'd127, 1'b0, 1'b0, 32'h34000000, 1'b0, 1'b0, 1'b0, 26, 0);
  endtask

  initial begin
    test_reset();
    test_normalize();
    test_rounding();
    test_overflow();
    test_denormal();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
